// File: rtl/buffer_pkg.sv
// Shared types and defaults for the packet-granular read scheduler.
package buffer_pkg;

    localparam int NUM_FLOWS_DEF = 4;
    localparam int FLOW_W_DEF    = $clog2(NUM_FLOWS_DEF);
    localparam int CNT_W_DEF     = 8;

    typedef logic [FLOW_W_DEF-1:0] flow_id_t;

    // IDLE: nothing offered; OFFER: rd_sel_valid high; ACTIVE: packet being drained
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        ACTIVE = 2'd2
    } sched_state_e;

    // Flow id following f, wrapping at n-1 back to 0.
    function automatic int next_flow(input int f, input int n);
        return (f + 1 >= n) ? 0 : f + 1;
    endfunction

endpackage

// File: rtl/buffer_read_sched_rr_arbiter.sv
// Combinational round-robin pick: first requesting flow at or after rr_ptr_i.
module rr_arbiter #(
    parameter int NUM_FLOWS = 4,
    parameter int FLOW_W    = $clog2(NUM_FLOWS)
) (
    input  logic [NUM_FLOWS-1:0] req_i,
    input  logic [FLOW_W-1:0]    rr_ptr_i,
    output logic                 any_grant_o,
    output logic [FLOW_W-1:0]    grant_id_o
);

    // Walk flows starting at the pointer, wrapping, and keep the first requester.
    always_comb begin : arb
        int          idx;
        logic [FLOW_W-1:0] idx_w;
        logic        found;
        idx         = 0;
        idx_w       = '0;
        found       = 1'b0;
        any_grant_o = 1'b0;
        grant_id_o  = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            idx   = (int'(rr_ptr_i) + i) % NUM_FLOWS;
            idx_w = FLOW_W'(idx);
            if (!found && req_i[idx_w]) begin
                found      = 1'b1;
                grant_id_o = idx_w;
            end
        end
        any_grant_o = found;
    end

endmodule

// File: rtl/buffer_read_sched.sv
// Round-robin, packet-granular scheduler choosing the next flow for buffer_read.
// Counts complete stored packets per flow, offers one flow, and holds the grant
// until the last beat of that packet is consumed.
//
// Handshake: rd_sel_valid/rd_sel_flow are registered and stay stable while
// rd_sel_valid is high and rd_sel_ready is low; the offer is never retracted.
// A cycle with rd_sel_valid & rd_sel_ready is the transfer; ready is ignored
// whenever no offer is outstanding.
module buffer_read_sched
    import buffer_pkg::*;
#(
    parameter int NUM_FLOWS = NUM_FLOWS_DEF,
    parameter int FLOW_W    = $clog2(NUM_FLOWS),
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_enq_valid,
    input  logic [FLOW_W-1:0]    pkt_enq_flow,
    input  logic [NUM_FLOWS-1:0] flow_enable,
    output logic                 rd_sel_valid,
    output logic [FLOW_W-1:0]    rd_sel_flow,
    input  logic                 rd_sel_ready,
    input  logic                 rd_pkt_done,
    output logic                 busy,
    output logic                 err_ovf,
    output logic                 err_unf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sched_state_e         state_q;
    logic                 rd_sel_valid_q;
    logic [FLOW_W-1:0]    rd_sel_flow_q;
    logic                 busy_q;
    logic [FLOW_W-1:0]    rr_ptr_q;
    logic                 err_ovf_q;
    logic                 err_unf_q;

    logic [CNT_W-1:0]     cnt_q [NUM_FLOWS];
    logic [CNT_W-1:0]     cnt_d [NUM_FLOWS];

    logic [NUM_FLOWS-1:0] enq_hit;
    logic [NUM_FLOWS-1:0] dec_hit;
    logic [NUM_FLOWS-1:0] eligible;
    logic                 done_active;
    logic                 ovf_hit;
    logic                 any_grant;
    logic [FLOW_W-1:0]    grant_id;

    assign done_active = rd_pkt_done && (state_q == ACTIVE);

    // Per-flow enqueue/dequeue strobes and eligibility from registered counts.
    always_comb begin
        enq_hit  = '0;
        dec_hit  = '0;
        eligible = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            enq_hit[f]  = pkt_enq_valid && (pkt_enq_flow == FLOW_W'(f));
            dec_hit[f]  = done_active && (rd_sel_flow_q == FLOW_W'(f));
            eligible[f] = flow_enable[f] && (cnt_q[f] != '0);
        end
    end

    // Next counter values: enq and done on the same flow cancel; saturate at max.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_hit = 1'b0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            if (enq_hit[f] && !dec_hit[f]) begin
                if (cnt_q[f] == CNT_MAX) begin
                    ovf_hit = 1'b1;
                end else begin
                    cnt_d[f] = cnt_q[f] + CNT_W'(1);
                end
            end else if (dec_hit[f] && !enq_hit[f] && (cnt_q[f] != '0)) begin
                cnt_d[f] = cnt_q[f] - CNT_W'(1);
            end
        end
    end

    // Stored-packet counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                cnt_q[f] <= '0;
            end
        end else begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                cnt_q[f] <= cnt_d[f];
            end
        end
    end

    rr_arbiter #(
        .NUM_FLOWS (NUM_FLOWS),
        .FLOW_W    (FLOW_W)
    ) u_arb (
        .req_i       (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .any_grant_o (any_grant),
        .grant_id_o  (grant_id)
    );

    // Scheduler FSM with registered offer, flow and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            rd_sel_valid_q <= 1'b0;
            rd_sel_flow_q  <= '0;
            busy_q         <= 1'b0;
            rr_ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_grant) begin
                        rd_sel_flow_q  <= grant_id;
                        rd_sel_valid_q <= 1'b1;
                        busy_q         <= 1'b1;
                        state_q        <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is held even if the flow gets disabled meanwhile.
                    if (rd_sel_ready) begin
                        rd_sel_valid_q <= 1'b0;
                        state_q        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (rd_pkt_done) begin
                        rr_ptr_q <= FLOW_W'(next_flow(int'(rd_sel_flow_q), NUM_FLOWS));
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    rd_sel_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags: saturated enqueue, completion without an active packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | ovf_hit;
            err_unf_q <= err_unf_q | (rd_pkt_done && (state_q != ACTIVE));
        end
    end

    assign rd_sel_valid = rd_sel_valid_q;
    assign rd_sel_flow  = rd_sel_flow_q;
    assign busy         = busy_q;
    assign err_ovf      = err_ovf_q;
    assign err_unf      = err_unf_q;

    a_offer_stable: assert property (@(posedge clk) disable iff (rst)
        (rd_sel_valid && !rd_sel_ready) |=> $stable(rd_sel_flow));

endmodule
